// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for param_register_file.
//   state_t            clear-engine state (ST_IDLE accepts traffic, ST_CLEAR sweeps entries)
//   *_DEF              default widths/counts used by the top-level parameters
//   DATA_W_MAX         widest supported register width
//   sel_wr_data()      picks the immediate or ALU operand as write data
package regfile_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int NUM_RD_DEF = 2;
    localparam int DATA_W_MAX = 64;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Operands arrive zero-extended to DATA_W_MAX; the caller keeps the low DATA_W bits.
    function automatic logic [DATA_W_MAX-1:0] sel_wr_data(
        input logic                  use_imm,
        input logic [DATA_W_MAX-1:0] alu,
        input logic [DATA_W_MAX-1:0] imm
    );
        return use_imm ? imm : alu;
    endfunction

endpackage

// File: rtl/param_register_file_if.sv
// param_register_file_if: bus between the control FSM/decoder/ALU (master)
// and the register file (slave).
//   we, wr_addr, wr_data_alu, wr_data_imm, reg_write_data_select : write request
//   resv_en, resv_addr                                         : reserve request
//   clear_req                                                  : start a full clear
//   rd_addr / rd_data / rd_pending                             : NUM_RD packed read ports
//   ready                                                      : register file is idle
//   fsm_state                                                  : clear-engine state, for observation
//
// Handshake: ready is the only flow control. A request (we, resv_en or
// clear_req) takes effect on a rising edge only if ready is 1 in that cycle;
// while ready is 0 requests are dropped without side effects and are not
// held or replayed, so the master must sample ready before relying on them.
interface param_register_file_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
);
    logic                     we;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data_alu;
    logic [DATA_W-1:0]        wr_data_imm;
    logic                     reg_write_data_select;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pending;
    logic                     resv_en;
    logic [ADDR_W-1:0]        resv_addr;
    logic                     clear_req;
    logic                     ready;
    state_t                   fsm_state;

    modport master (
        output we, wr_addr, wr_data_alu, wr_data_imm, reg_write_data_select,
        output rd_addr, resv_en, resv_addr, clear_req,
        input  rd_data, rd_pending, ready, fsm_state
    );

    modport slave (
        input  we, wr_addr, wr_data_alu, wr_data_imm, reg_write_data_select,
        input  rd_addr, resv_en, resv_addr, clear_req,
        output rd_data, rd_pending, ready, fsm_state
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one pending bit per register entry.
//   clk, rst_n      clock, synchronous active-low reset (clears every bit)
//   flush           clear all bits (start of a clear sweep)
//   wr_acc/wr_addr  accepted write: clears the entry's bit
//   resv_acc/resv_addr accepted reserve: sets the entry's bit, beats a same-entry write
//   ready           register file idle; lookups read 0 otherwise
//   rd_addr         packed read addresses, rd_pending one bit per port
module regfile_scoreboard #(
    parameter int ADDR_W = 3,
    parameter int NUM_RD = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_acc,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     resv_acc,
    input  logic [ADDR_W-1:0]        resv_addr,
    input  logic                     ready,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_pending
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] pending;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (resv_acc && resv_addr == ADDR_W'(i)) begin
                    pending[i] <= 1'b1;
                end else if (wr_acc && wr_addr == ADDR_W'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic              fwd_clr;
        assign addr = rd_addr[p*ADDR_W +: ADDR_W];
        // A write landing this cycle satisfies the operand early, unless a
        // reserve on the same entry keeps it in flight.
        assign fwd_clr = BYPASS && wr_acc && (wr_addr == addr) &&
                         !(resv_acc && (resv_addr == addr));
        assign rd_pending[p] = ready && pending[addr] && !fwd_clr;
    end

endmodule

// File: rtl/param_register_file.sv
// param_register_file: parametrised register file with clear engine,
// optional zero register, write-to-read bypass and pending scoreboard.
//   clk    single clock, all state on rising edge
//   rst_n  synchronous active-low reset; starts a clear sweep
//   bus    param_register_file_if.slave: write, reserve, clear and NUM_RD read ports
module param_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    param_register_file_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic                  ready;
    logic                  wr_acc;
    logic                  resv_acc;
    logic [DATA_W_MAX-1:0] wr_data_full;
    logic [DATA_W-1:0]     wr_data;

    assign ready         = (state == ST_IDLE);
    assign bus.ready     = ready;
    assign bus.fsm_state = state;

    assign wr_acc   = bus.we && ready && !(ZERO_REG && bus.wr_addr == '0);
    assign resv_acc = bus.resv_en && ready && !(ZERO_REG && bus.resv_addr == '0);

    assign wr_data_full = sel_wr_data(bus.reg_write_data_select,
                                      DATA_W_MAX'(bus.wr_data_alu),
                                      DATA_W_MAX'(bus.wr_data_imm));
    assign wr_data      = wr_data_full[DATA_W-1:0];

    // Clear engine: one entry per cycle, back to IDLE after the last entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_ptr <= clr_ptr + ADDR_W'(1);
                    if (clr_ptr == ADDR_W'(DEPTH-1)) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (bus.clear_req) begin
                        state   <= ST_CLEAR;
                        clr_ptr <= '0;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_ptr <= '0;
                end
            endcase
        end
    end

    // Storage has no reset of its own; the clear sweep zeroes it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_acc) begin
                mem[bus.wr_addr] <= wr_data;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (ready && bus.clear_req),
        .wr_acc     (wr_acc),
        .wr_addr    (bus.wr_addr),
        .resv_acc   (resv_acc),
        .resv_addr  (bus.resv_addr),
        .ready      (ready),
        .rd_addr    (bus.rd_addr),
        .rd_pending (bus.rd_pending)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        assign addr = bus.rd_addr[p*ADDR_W +: ADDR_W];
        always_comb begin
            data = '0;
            if (!ready) begin
                data = '0;
            end else if (ZERO_REG && addr == '0) begin
                data = '0;
            end else if (BYPASS && wr_acc && bus.wr_addr == addr) begin
                data = wr_data;
            end else begin
                data = mem[addr];
            end
        end
        assign bus.rd_data[p*DATA_W +: DATA_W] = data;
    end

endmodule
